// File: rtl/mem_seq_pkg.sv
// Shared types for the memory sequencer: operation encoding, FSM states and
// the width of the read-latency counter.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    OP_STORE_REGS = 2'd0,
    OP_LOAD_REGS  = 2'd1,
    OP_STORE_BCD  = 2'd2,
    OP_ILLEGAL    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_FIN     = 3'd4
  } state_e;

  // Wide enough to count up to the largest read latency (4).
  localparam int LAT_W = 3;

endpackage

// File: rtl/mem_seq_if.sv
// Memory request bus between the sequencer (master) and the memory arbiter (slave).
interface mem_seq_if #(
  parameter int ADDR_W = 12
) ();

  // Handshake: mem_req is the valid, mem_gnt the ready. A request completes in a
  // cycle with both high; while mem_gnt is low the master holds mem_req and every
  // request field stable. Read data arrives on mem_rdata a fixed latency later.
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_gnt;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rdata
  );

endinterface

// File: rtl/mem_seq_bcd8.sv
// Combinational split of an 8-bit binary value into hundreds, tens and ones digits.
module bcd8 (
  input  logic [7:0] bin,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  assign hundreds = 4'(bin / 8'd100);
  assign tens     = 4'((bin / 8'd10) % 8'd10);
  assign ones     = 4'(bin % 8'd10);

endmodule

// File: rtl/mem_seq.sv
// Register-block / BCD memory sequencer: moves V0..Vx to or from memory at I,
// or stores the three BCD digits of Vx, one byte per granted request.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter  int NUM_REGS    = 16,
  parameter  int ADDR_W      = 12,
  parameter  int MEM_LAT     = 1,
  parameter  int I_INC_QUIRK = 0,
  localparam int IDX_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [IDX_W-1:0] x,
  input  logic [15:0]      I_in,
  input  logic [7:0]       vx,
  output logic [IDX_W-1:0] reg_rd_idx,
  input  logic [7:0]       reg_rd_data,
  output logic             reg_wr_en,
  output logic [IDX_W-1:0] reg_wr_idx,
  output logic [7:0]       reg_wr_data,
  mem_seq_if.master        mem,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      I_out,
  output logic             I_wr_en,
  output state_e           dbg_state
);

  // The counter must reach 2 for the BCD digits even with a tiny register file.
  localparam int K_W = (IDX_W < 2) ? 2 : IDX_W;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [IDX_W-1:0]  x_q, x_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [7:0]        vx_q, vx_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              err_q, err_d;

  logic [3:0]        bcd_h, bcd_t, bcd_o;
  logic [7:0]        bcd_byte;
  logic [ADDR_W-1:0] addr_k;
  logic              last_reg;

  bcd8 u_bcd8 (
    .bin      (vx_q),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .ones     (bcd_o)
  );

  assign addr_k    = i_q + ADDR_W'(k_q);
  assign last_reg  = (k_q == K_W'(x_q));
  assign busy      = (state_q == ST_WR) || (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
  assign err       = err_q;
  assign dbg_state = state_q;

  always_comb begin
    case (k_q[1:0])
      2'd0:    bcd_byte = {4'd0, bcd_h};
      2'd1:    bcd_byte = {4'd0, bcd_t};
      default: bcd_byte = {4'd0, bcd_o};
    endcase
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    x_d           = x_q;
    i_d           = i_q;
    vx_d          = vx_q;
    k_d           = k_q;
    lat_d         = lat_q;
    err_d         = 1'b0;
    reg_rd_idx    = '0;
    reg_wr_en     = 1'b0;
    reg_wr_idx    = '0;
    reg_wr_data   = '0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    done          = 1'b0;
    I_wr_en       = 1'b0;
    I_out         = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op_e'(op);
          x_d   = x;
          i_d   = I_in[ADDR_W-1:0];
          vx_d  = vx;
          k_d   = '0;
          lat_d = '0;
          case (op_e'(op))
            OP_STORE_REGS, OP_STORE_BCD: state_d = ST_WR;
            OP_LOAD_REGS:                state_d = ST_RD_REQ;
            default:                     err_d   = 1'b1;
          endcase
        end
      end

      // Request fields depend only on registered state, so they hold while stalled.
      ST_WR: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_addr = addr_k;
        if (op_q == OP_STORE_BCD) begin
          mem.mem_wdata = bcd_byte;
        end else begin
          reg_rd_idx    = k_q[IDX_W-1:0];
          mem.mem_wdata = reg_rd_data;
        end
        if (mem.mem_gnt) begin
          if ((op_q == OP_STORE_BCD) ? (k_q == K_W'(2)) : last_reg) begin
            state_d = ST_FIN;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end

      ST_RD_REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = addr_k;
        if (mem.mem_gnt) begin
          lat_d   = LAT_W'(1);
          state_d = ST_RD_WAIT;
        end
      end

      // lat_q counts cycles since the grant; data is valid when it reaches MEM_LAT.
      ST_RD_WAIT: begin
        if (lat_q == LAT_W'(MEM_LAT)) begin
          reg_wr_en   = 1'b1;
          reg_wr_idx  = k_q[IDX_W-1:0];
          reg_wr_data = mem.mem_rdata;
          if (last_reg) begin
            state_d = ST_FIN;
          end else begin
            k_d     = k_q + K_W'(1);
            state_d = ST_RD_REQ;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
        if ((I_INC_QUIRK != 0) && (op_q != OP_STORE_BCD)) begin
          I_wr_en = 1'b1;
          I_out   = I_in + 16'(x_q) + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_STORE_REGS;
      x_q     <= '0;
      i_q     <= '0;
      vx_q    <= '0;
      k_q     <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      i_q     <= i_d;
      vx_q    <= vx_d;
      k_q     <= k_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq: register-file and memory models, a write scoreboard
// and hand-computed expectations for BCD, store, load, stall, wrap, illegal and reset cases.
module tb_mem_seq;
  import mem_seq_pkg::*;

  localparam int NUM_REGS    = 16;
  localparam int ADDR_W      = 12;
  localparam int MEM_LAT     = 2;
  localparam int I_INC_QUIRK = 1;
  localparam int IDX_W       = 4;
  localparam int NONE        = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start;
  logic [1:0]       op;
  logic [IDX_W-1:0] x;
  logic [15:0]      I_in;
  logic [7:0]       vx;
  logic [IDX_W-1:0] reg_rd_idx;
  logic [7:0]       reg_rd_data;
  logic             reg_wr_en;
  logic [IDX_W-1:0] reg_wr_idx;
  logic [7:0]       reg_wr_data;
  logic             busy, done, err;
  logic [15:0]      I_out;
  logic             I_wr_en;
  state_e           dbg_state;

  mem_seq_if #(.ADDR_W(ADDR_W)) mem_bus ();

  mem_seq #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .I_INC_QUIRK(I_INC_QUIRK)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .I_in(I_in), .vx(vx),
    .reg_rd_idx(reg_rd_idx), .reg_rd_data(reg_rd_data),
    .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
    .mem(mem_bus), .busy(busy), .done(done), .err(err),
    .I_out(I_out), .I_wr_en(I_wr_en), .dbg_state(dbg_state)
  );

  // ---------------- register file and memory models ----------------
  logic [7:0]        regs    [NUM_REGS];
  logic [7:0]        mem_arr [1<<ADDR_W];
  logic              tb_reg_wr = 1'b0, tb_mem_wr = 1'b0;
  logic [IDX_W-1:0]  tb_reg_idx = '0;
  logic [ADDR_W-1:0] tb_mem_addr = '0;
  logic [7:0]        tb_data = '0;
  logic              p1_v = 1'b0, p2_v = 1'b0;
  logic [ADDR_W-1:0] p1_a = '0, p2_a = '0;

  always @(posedge clk) begin
    if (reg_wr_en) regs[reg_wr_idx] <= reg_wr_data;
    else if (tb_reg_wr) regs[tb_reg_idx] <= tb_data;
    if (mem_bus.mem_req && mem_bus.mem_gnt && mem_bus.mem_we) mem_arr[mem_bus.mem_addr] <= mem_bus.mem_wdata;
    else if (tb_mem_wr) mem_arr[tb_mem_addr] <= tb_data;
    p1_v <= mem_bus.mem_req && mem_bus.mem_gnt && !mem_bus.mem_we;
    p1_a <= mem_bus.mem_addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end

  assign reg_rd_data       = regs[reg_rd_idx];
  assign mem_bus.mem_rdata = p2_v ? mem_arr[p2_a] : 8'h00;

  // ---------------- monitor / scoreboard ----------------
  int          cyc = 0;
  int          req_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [19:0] obs_q[$];
  logic [19:0] exp_q[$];
  int          rd_gnt_cyc[$];
  int          rw_cyc[$];
  int          n_checks = 0, n_errors = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_bus.mem_req) req_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (mem_bus.mem_req && mem_bus.mem_gnt) begin
      if (mem_bus.mem_we) obs_q.push_back({mem_bus.mem_addr, mem_bus.mem_wdata});
      else rd_gnt_cyc.push_back(cyc);
    end
    if (reg_wr_en) rw_cyc.push_back(cyc);
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check_val({tag, "_nwr"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check_val(tag, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke_reg(input logic [IDX_W-1:0] idx, input logic [7:0] d);
    @(posedge clk); #1;
    tb_reg_wr = 1'b1; tb_reg_idx = idx; tb_data = d;
    @(posedge clk); #1;
    tb_reg_wr = 1'b0;
  endtask

  task automatic poke_mem(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    tb_mem_wr = 1'b1; tb_mem_addr = a; tb_data = d;
    @(posedge clk); #1;
    tb_mem_wr = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Issues one operation, optionally stalling the grant for 3 cycles from
  // cycle stall_at and pulsing a second start at cycle bs_at; lat is the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [3:0] xx, input logic [15:0] ii,
                        input logic [7:0] v, input int stall_at, input int bs_at,
                        output int lat, output logic busy1, output logic iwr,
                        output logic [15:0] iout);
    logic              prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [7:0]        prev_wdata;
    lat = -1; busy1 = 1'b0; iwr = 1'b0; iout = '0;
    prev_stall = 1'b0; prev_addr = '0; prev_wdata = '0;
    @(posedge clk); #1;
    start = 1'b1; op = o; x = xx; I_in = ii; vx = v; mem_bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n < 100; n++) begin
      start = (n == bs_at);
      if (n == bs_at) begin
        op = 2'd2; x = 4'd7; I_in = 16'h0600; vx = 8'd99;
      end else begin
        op = o; x = xx; I_in = ii; vx = v;
      end
      mem_bus.mem_gnt = !(n >= stall_at && n < stall_at + 3);
      @(negedge clk);
      if (n == 1) busy1 = busy;
      if (prev_stall) begin
        check_val("stall_req", mem_bus.mem_req, 1);
        check_val("stall_addr", mem_bus.mem_addr, prev_addr);
        check_val("stall_wdata", mem_bus.mem_wdata, prev_wdata);
      end
      prev_stall = mem_bus.mem_req && !mem_bus.mem_gnt;
      prev_addr  = mem_bus.mem_addr;
      prev_wdata = mem_bus.mem_wdata;
      if (I_wr_en) begin
        iwr = 1'b1; iout = I_out;
      end
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; mem_bus.mem_gnt = 1'b1; I_in = ii;
  endtask

  // ---------------- stimulus ----------------
  int          lat, d0, e0, r0;
  logic        busy1, iwr;
  logic [15:0] iout;

  initial begin
    rst = 1'b0; start = 1'b0; op = '0; x = '0; I_in = '0; vx = '0;
    mem_bus.mem_gnt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_req", mem_bus.mem_req, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    check_val("rst_iwr", I_wr_en, 0);
    check_val("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("post_rst_done", done_cnt, 0);
    check_val("post_rst_wr", obs_q.size(), 0);

    poke_reg(4'd0, 8'h11); poke_reg(4'd1, 8'h22); poke_reg(4'd2, 8'h33);
    poke_reg(4'd3, 8'h44); poke_reg(4'd4, 8'h55); poke_reg(4'd5, 8'h66);
    poke_mem(12'h400, 8'hAB); poke_mem(12'h401, 8'hCD);
    obs_q.delete();

    // BCD of 237 at 0x300
    d0 = done_cnt;
    run_op(2'd2, 4'd0, 16'h0300, 8'd237, NONE, NONE, lat, busy1, iwr, iout);
    settle();
    check_val("bcd_lat", lat, 4);
    check_val("bcd_busy1", busy1, 1);
    check_val("bcd_iwr", iwr, 0);
    check_val("bcd_done1", done_cnt - d0, 1);
    exp_q.push_back({12'h300, 8'd2});
    exp_q.push_back({12'h301, 8'd3});
    exp_q.push_back({12'h302, 8'd7});
    check_writes("bcd_wr");

    // store V0..V3 at 0x200
    run_op(2'd0, 4'd3, 16'h0200, 8'd0, NONE, NONE, lat, busy1, iwr, iout);
    settle();
    check_val("st_lat", lat, 5);
    check_val("st_iwr", iwr, 1);
    check_val("st_iout", iout, 16'h0204);
    for (int i = 0; i < 4; i++) exp_q.push_back({12'h200 + 12'(i), 8'h11 * 8'(i + 1)});
    check_writes("st_wr");

    // store with a 3-cycle grant stall on the second byte and a start while busy
    e0 = err_cnt;
    run_op(2'd0, 4'd3, 16'h0210, 8'd0, 2, 3, lat, busy1, iwr, iout);
    settle();
    check_val("stall_lat", lat, 8);
    check_val("stall_iout", iout, 16'h0214);
    check_val("busy_start_err", err_cnt - e0, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back({12'h210 + 12'(i), 8'h11 * 8'(i + 1)});
    check_writes("stall_wr");

    // load V0,V1 from 0x400
    rd_gnt_cyc.delete(); rw_cyc.delete();
    run_op(2'd1, 4'd1, 16'h0400, 8'd0, NONE, NONE, lat, busy1, iwr, iout);
    settle();
    check_val("ld_lat", lat, 7);
    check_val("ld_iout", iout, 16'h0402);
    check_val("ld_v0", regs[0], 8'hAB);
    check_val("ld_v1", regs[1], 8'hCD);
    check_val("ld_ngnt", rd_gnt_cyc.size(), 2);
    check_val("ld_nwr", rw_cyc.size(), 2);
    while (rd_gnt_cyc.size() > 0 && rw_cyc.size() > 0)
      check_val("ld_wr_lat", rw_cyc.pop_front() - rd_gnt_cyc.pop_front(), 2);
    check_writes("ld_memwr");

    // address wrap: I=0xFFFF, x=1
    run_op(2'd0, 4'd1, 16'hFFFF, 8'd0, NONE, NONE, lat, busy1, iwr, iout);
    settle();
    check_val("wrap_lat", lat, 3);
    check_val("wrap_iout", iout, 16'h0001);
    exp_q.push_back({12'hFFF, 8'hAB});
    exp_q.push_back({12'h000, 8'hCD});
    check_writes("wrap_wr");

    // illegal op
    r0 = req_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; op = 2'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 2'd0;
    @(negedge clk);
    check_val("ill_err", err, 1);
    check_val("ill_busy", busy, 0);
    check_val("ill_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("ill_err_pulse", err, 0);
    repeat (4) @(posedge clk);
    #1;
    check_val("ill_req", req_cnt - r0, 0);
    check_val("ill_done", done_cnt - d0, 0);

    // reset during the second write of an x=5 store
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; op = 2'd0; x = 4'd5; I_in = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check_val("mid_req", mem_bus.mem_req, 1);
    check_val("mid_addr", mem_bus.mem_addr, 12'h101);
    rst = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_req", mem_bus.mem_req, 0);
    check_val("mid_rst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("mid_rst_done", done_cnt - d0, 0);
    exp_q.push_back({12'h100, 8'hAB});
    check_writes("mid_rst_wr");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 Parameter NUM_REGS, default 16: number of V registers; the register index width is log2(NUM_REGS).
REQ-002 Parameter ADDR_W, default 12: memory address width; all address arithmetic is modulo 2^ADDR_W.
REQ-003 Parameter MEM_LAT, default 1, range 1-4: cycles from a granted read to valid mem_rdata.
REQ-004 Parameter I_INC_QUIRK, default 0: when 1, the final I value is written back as I+x+1.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request pulse from execute.
REQ-008 op  in  2  operation: 0 STORE_REGS (LD [I],Vx), 1 LOAD_REGS (LD Vx,[I]), 2 STORE_BCD (LD B,Vx), 3 illegal.
REQ-009 x  in  log2(NUM_REGS)  index of the last register to transfer.
REQ-010 I_in  in  16  current I register value.
REQ-011 vx  in  8  value of Vx, sampled at start.
REQ-012 reg_rd_idx  out  log2(NUM_REGS)  register-file read index; the register file returns reg_rd_data in the same cycle.
REQ-013 reg_rd_data  in  8  combinational register-file read data.
REQ-014 reg_wr_en, reg_wr_idx, reg_wr_data  out  1/log2(NUM_REGS)/8  register write port.
REQ-015 mem_req, mem_we, mem_addr, mem_wdata  out  1/1/ADDR_W/8  memory request.
REQ-016 mem_gnt  in  1  arbiter grant; a request completes in the cycle in which mem_req and mem_gnt are both high.
REQ-017 mem_rdata  in  8  read data, valid exactly MEM_LAT cycles after a granted read.
REQ-018 busy  out  1  stall request to the pipeline.
REQ-019 done  out  1  one-cycle completion pulse.
REQ-020 err  out  1  one-cycle illegal-op pulse.
REQ-021 I_out, I_wr_en  out  16/1  I write-back.

Function
REQ-022 States: IDLE, WR, RD_REQ, RD_WAIT, FIN.
REQ-023 In IDLE, start with op 0 or 2 SHALL go to WR, and start with op 1 SHALL go to RD_REQ; busy SHALL rise in the cycle after start.
REQ-024 At start, the block SHALL latch op, x, I_in[ADDR_W-1:0] and vx, and clear the counter k.
REQ-025 STORE_REGS: in WR, drive mem_we=1, mem_addr=I+k, reg_rd_idx=k and mem_wdata=reg_rd_data; on grant, if k==x go to FIN, else increment k.
REQ-026 STORE_BCD: in WR, write vx/100 at I, (vx/10)%10 at I+1 and vx%10 at I+2, one byte per grant; after the third grant go to FIN.
REQ-027 LOAD_REGS: in RD_REQ, drive a read at I+k; on grant go to RD_WAIT.
REQ-028 LOAD_REGS: in RD_WAIT, after MEM_LAT cycles assert reg_wr_en with reg_wr_idx=k and reg_wr_data=mem_rdata; then go to FIN if k==x, else increment k and return to RD_REQ.
REQ-029 In any state, while mem_gnt is low, mem_req and all request fields SHALL stay stable.
REQ-030 FIN: pulse done for one cycle and return to IDLE; busy SHALL be low from FIN onward.
REQ-031 In FIN, when I_INC_QUIRK=1 and op is 0 or 1, pulse I_wr_en with I_out = I_in + x + 1 (16-bit, wrapping); otherwise I_wr_en stays 0.
REQ-032 Illegal op: pulse err the cycle after start, make no memory access, assert no done, and stay in IDLE.
REQ-033 start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-034 Addresses SHALL wrap: for example, I=0xFFF with k=1 gives mem_addr 0x000 when ADDR_W=12.
REQ-035 Outside the active states, mem_req, reg_wr_en, done, err and I_wr_en SHALL be 0.

Reset
REQ-036 While rst is low, state is IDLE, k=0, all latches are 0, and all outputs are 0, including in the middle of an operation.
REQ-037 After rst is released, no stale write or done pulse SHALL occur.

Structure
REQ-038 The op encoding enum and the state enum belong in the shared types package.
REQ-039 The BCD digit split is a combinational sub-module named bcd8 (8-bit input; hundreds, tens and ones as 4-bit outputs).

Verification
REQ-040 BCD: op=2, vx=8'd237, I=0x300, mem_gnt tied high -> writes 2@0x300, 3@0x301, 7@0x302; done 4 cycles after start.
REQ-041 Store: op=0, x=3, V0..V3=0x11,0x22,0x33,0x44, I=0x200 -> four consecutive writes at 0x200-0x203; with I_INC_QUIRK=1, I_out=0x204.
REQ-042 Load: op=1, x=1, MEM_LAT=2, mem holds 0xAB@0x400 and 0xCD@0x401 -> V0=0xAB and V1=0xCD; each reg_wr_en occurs 2 cycles after its grant.
REQ-043 Grant stall: mem_gnt low for 3 cycles during a store -> mem_addr and mem_wdata held stable, no skipped or duplicated bytes.
REQ-044 Reset mid-transfer: rst low during the second write of an x=5 store -> busy=0 and mem_req=0 immediately, with no done pulse.
REQ-045 Illegal op and busy start: op=3 -> err pulse and no mem_req; a start issued while busy -> ignored.
